// File: rtl/seq_ctrl_pkg.sv
// Shared types for the programmable sequence-detect controller:
// FSM state encoding and run status codes.
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_HIT     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORT   = 2'b11;

endpackage

// File: rtl/seq_match_core.sv
// History shift register, saturating fill counter and length-masked compare.
// SEQ_CTRL_OVERLAP_EN keeps fill after a match so matches may overlap.
module seq_match_core
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             a,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             hit
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

    // Only PAT_W-1 past bits are stored; the newest bit of the window is a itself.
    logic [PAT_W-2:0] r_hist;
    logic [LEN_W-1:0] r_fill;

    logic [PAT_W-1:0] w_hist_next;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W-1:0] w_fill_next;
    logic             w_hit;

    assign w_hist_next = {r_hist, a};
    assign w_fill_next = (r_fill == FILL_MAX) ? r_fill : r_fill + LEN_W'(1);

    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
        assign w_mask[gi] = (LEN_W'(gi) < len);
    end

    assign w_hit = shift_en && (w_fill_next >= len)
                && (((w_hist_next ^ pattern) & w_mask) == '0);
    assign hit   = w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (shift_en) begin
            r_hist <= w_hist_next[PAT_W-2:0];
`ifdef SEQ_CTRL_OVERLAP_EN
            r_fill <= w_fill_next;
`else
            r_fill <= w_hit ? '0 : w_fill_next;
`endif
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Controller: config handshake, IDLE/ARM/SCAN/DONE sequencing, run counters.
// Overlap behaviour selected by SEQ_CTRL_OVERLAP_EN inside seq_match_core.
module seq_detect_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [PAT_W-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
    input  logic [CNT_W-1:0]           cfg_limit,
    input  logic [WIN_W-1:0]           cfg_window,
    input  logic                       abort,
    input  logic                       a,
    input  logic                       a_valid,
    output logic                       match,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 status,
    output logic [CNT_W-1:0]           match_cnt
);
    import seq_ctrl_pkg::*;

    localparam int               LEN_W   = $clog2(PAT_W + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    state_t           r_state;
    logic             r_cfg_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_match;
    logic [1:0]       r_status;
    logic [CNT_W-1:0] r_match_cnt;
    logic [WIN_W-1:0] r_bit_cnt;
    logic [PAT_W-1:0] r_pattern;
    logic [LEN_W-1:0] r_len;
    logic [CNT_W-1:0] r_limit;
    logic [WIN_W-1:0] r_window;

    logic             w_accept;
    logic             w_shift;
    logic             w_hit;
    logic [LEN_W-1:0] w_len_clamped;
    logic [CNT_W-1:0] w_cnt_next;
    logic [WIN_W-1:0] w_bit_next;
    logic             w_limit_hit;
    logic             w_timeout;

    always_comb begin
        w_len_clamped = cfg_len;
        if (cfg_len == '0) begin
            w_len_clamped = LEN_W'(1);
        end else if (cfg_len > LEN_MAX) begin
            w_len_clamped = LEN_MAX;
        end
    end

    assign w_accept = cfg_valid && r_cfg_ready;
    // Abort wins over a same-cycle bit, so that bit never reaches the core.
    assign w_shift  = (r_state == SCAN) && a_valid && !abort;

    seq_match_core #(
        .PAT_W (PAT_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (r_state == ARM),
        .shift_en (w_shift),
        .a        (a),
        .pattern  (r_pattern),
        .len      (r_len),
        .hit      (w_hit)
    );

    assign w_cnt_next  = (w_hit && !(&r_match_cnt)) ? r_match_cnt + CNT_W'(1) : r_match_cnt;
    assign w_bit_next  = r_bit_cnt + WIN_W'(1);
    assign w_limit_hit = (r_limit != '0) && (w_cnt_next == r_limit);
    assign w_timeout   = (r_window != '0) && (w_bit_next == r_window);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_match     <= 1'b0;
            r_status    <= ST_NONE;
            r_match_cnt <= '0;
            r_bit_cnt   <= '0;
            r_pattern   <= '0;
            r_len       <= '0;
            r_limit     <= '0;
            r_window    <= '0;
        end else begin
            r_match <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_pattern   <= cfg_pattern;
                        r_len       <= w_len_clamped;
                        r_limit     <= cfg_limit;
                        r_window    <= cfg_window;
                        r_status    <= ST_NONE;
                        r_match_cnt <= '0;
                        r_cfg_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ARM;
                    end
                end
                ARM: begin
                    r_bit_cnt <= '0;
                    r_state   <= SCAN;
                end
                SCAN: begin
                    if (abort) begin
                        r_status <= ST_ABORT;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else if (a_valid) begin
                        r_bit_cnt   <= w_bit_next;
                        r_match_cnt <= w_cnt_next;
                        r_match     <= w_hit;
                        // Hit outranks a timeout landing on the same bit.
                        if (w_limit_hit) begin
                            r_status <= ST_HIT;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end else if (w_timeout) begin
                            r_status <= ST_TIMEOUT;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_cfg_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign match     = r_match;
    assign status    = r_status;
    assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: table vectors, hand corner cases, random runs
// against a queue-based reference model (honours SEQ_CTRL_OVERLAP_EN).
`timescale 1ns/1ps
module tb_seq_detect_ctrl;
    import seq_ctrl_pkg::*;

    localparam int PAT_W = 8;
    localparam int CNT_W = 8;
    localparam int WIN_W = 16;
`ifdef SEQ_CTRL_OVERLAP_EN
    localparam int OVL = 1;
`else
    localparam int OVL = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [7:0]       cfg_pattern = '0;
    logic [3:0]       cfg_len = '0;
    logic [7:0]       cfg_limit = '0;
    logic [15:0]      cfg_window = '0;
    logic             abort = 1'b0;
    logic             a = 1'b0;
    logic             a_valid = 1'b0;
    logic             match;
    logic             busy;
    logic             done;
    logic [1:0]       status;
    logic [7:0]       match_cnt;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_limit(cfg_limit),
        .cfg_window(cfg_window), .abort(abort), .a(a), .a_valid(a_valid),
        .match(match), .busy(busy), .done(done), .status(status), .match_cnt(match_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference model: bits since the last match boundary kept in a queue.
    logic [7:0] m_pat;
    int         m_len, m_lim, m_win, m_cnt, m_bits;
    bit         m_q[$];

    function automatic int clamp_len(input int l);
        if (l == 0) return 1;
        if (l > PAT_W) return PAT_W;
        return l;
    endfunction

    task automatic model_step(input bit v, input bit b, input bit ab,
                              output bit mt, output bit dn, output logic [1:0] st);
        mt = 1'b0; dn = 1'b0; st = ST_NONE;
        if (ab) begin
            dn = 1'b1; st = ST_ABORT;
        end else if (v) begin
            m_bits++;
            m_q.push_back(b);
            if (m_q.size() > PAT_W) void'(m_q.pop_front());
            if (m_q.size() >= m_len) begin
                mt = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (m_q[m_q.size() - 1 - i] != m_pat[i]) mt = 1'b0;
            end
            if (mt) begin
                if (m_cnt < 255) m_cnt++;
                if (OVL == 0) m_q.delete();
            end
            if (m_lim != 0 && m_cnt == m_lim) begin
                dn = 1'b1; st = ST_HIT;
            end else if (m_win != 0 && (m_bits % 65536) == m_win) begin
                dn = 1'b1; st = ST_TIMEOUT;
            end
        end
    endtask

    bit         stim_v[64], stim_a[64], stim_ab[64];
    int         stim_n;
    int         got_cnt, dut_done_at, dut_matches;
    logic [1:0] got_st;

    task automatic run_case(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] lim,
                            input logic [15:0] win, input string tag);
        int w, idx;
        bit mt, dn;
        logic [1:0] st, exp_st;
        w = 0;
        while (cfg_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check({tag, " ready"}, 32'(cfg_ready), 32'(1));
        cfg_pattern = pat; cfg_len = len; cfg_limit = lim; cfg_window = win; cfg_valid = 1'b1;
        a_valid = 1'($urandom_range(0, 1)); a = 1'($urandom_range(0, 1)); abort = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check({tag, " acc ready"}, 32'(cfg_ready), 32'(0));
        check({tag, " acc busy"}, 32'(busy), 32'(1));
        check({tag, " acc status"}, 32'(status), 32'(ST_NONE));
        check({tag, " acc cnt"}, 32'(match_cnt), 32'(0));
        m_pat = pat; m_len = clamp_len(int'(len)); m_lim = int'(lim); m_win = int'(win);
        m_cnt = 0; m_bits = 0; m_q.delete();
        // ARM cycle: bit and abort must both be ignored.
        a_valid = 1'b1; a = 1'($urandom_range(0, 1)); abort = 1'b1;
        @(posedge clk); #1;
        check({tag, " arm busy"}, 32'(busy), 32'(1));
        check({tag, " arm done"}, 32'(done), 32'(0));
        dn = 1'b0; idx = 0; exp_st = ST_NONE; dut_done_at = 0; dut_matches = 0;
        while (!dn) begin
            if (idx < stim_n) begin
                a_valid = stim_v[idx]; a = stim_a[idx]; abort = stim_ab[idx];
            end else begin
                a_valid = 1'b0; a = 1'b0; abort = 1'b1;
            end
            idx++;
            model_step(a_valid, a, abort, mt, dn, st);
            @(posedge clk); #1;
            if (match === 1'b1) dut_matches++;
            if (done === 1'b1 && dut_done_at == 0) dut_done_at = idx;
            check({tag, " match"}, 32'(match), 32'(mt));
            check({tag, " done"}, 32'(done), 32'(dn));
            check({tag, " busy"}, 32'(busy), 32'(!dn));
            check({tag, " cnt"}, 32'(match_cnt), 32'(m_cnt));
            if (dn) exp_st = st;
        end
        check({tag, " status"}, 32'(status), 32'(exp_st));
        got_cnt = int'(match_cnt); got_st = status;
        a_valid = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        check({tag, " post ready"}, 32'(cfg_ready), 32'(1));
        check({tag, " post done"}, 32'(done), 32'(0));
        check({tag, " post status"}, 32'(status), 32'(exp_st));
        check({tag, " post cnt"}, 32'(match_cnt), 32'(m_cnt));
    endtask

    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  len;
        logic [7:0]  lim;
        logic [15:0] win;
        logic [15:0] bits;   // bit i is the i-th streamed bit
        int          n;
        int          exp_cnt;
        logic [1:0]  exp_st;
        int          exp_at;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{8'h71, 4'd8,  8'd1, 16'd0,  16'h008E, 8, 1, ST_HIT, 8};
        tbl[1] = '{8'h0F, 4'd4,  8'd1, 16'd6,  16'h0000, 6, 0, ST_TIMEOUT, 6};
        tbl[2] = '{8'h05, 4'd3,  8'd0, 16'd5,  16'h0015, 5, (OVL != 0) ? 2 : 1, ST_TIMEOUT, 5};
        tbl[3] = '{8'h03, 4'd2,  8'd1, 16'd2,  16'h0003, 2, 1, ST_HIT, 2};
        tbl[4] = '{8'hFE, 4'd0,  8'd2, 16'd10, 16'h000B, 5, 2, ST_HIT, 5};
        tbl[5] = '{8'hA5, 4'd12, 8'd1, 16'd0,  16'h00A5, 8, 1, ST_HIT, 8};
        tbl[6] = '{8'h01, 4'd1,  8'd2, 16'd3,  16'h0004, 3, 1, ST_TIMEOUT, 3};
        tbl[7] = '{8'h03, 4'd2,  8'd2, 16'd0,  16'h000F, 4, 2, ST_HIT, (OVL != 0) ? 3 : 4};

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst cfg_ready", 32'(cfg_ready), 32'(1));
        check("rst busy", 32'(busy), 32'(0));
        check("rst done", 32'(done), 32'(0));
        check("rst match", 32'(match), 32'(0));
        check("rst status", 32'(status), 32'(ST_NONE));
        check("rst cnt", 32'(match_cnt), 32'(0));
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 8; t++) begin
            stim_n = tbl[t].n;
            for (int i = 0; i < stim_n; i++) begin
                stim_v[i] = 1'b1; stim_a[i] = tbl[t].bits[i]; stim_ab[i] = 1'b0;
            end
            run_case(tbl[t].pat, tbl[t].len, tbl[t].lim, tbl[t].win, $sformatf("tbl%0d", t));
            check($sformatf("tbl%0d final cnt", t), 32'(got_cnt), 32'(tbl[t].exp_cnt));
            check($sformatf("tbl%0d final status", t), 32'(got_st), 32'(tbl[t].exp_st));
            check($sformatf("tbl%0d done at", t), 32'(dut_done_at), 32'(tbl[t].exp_at));
        end

        // Abort with gaps: the bit that would complete 1011 arrives with abort.
        stim_n = 7;
        stim_v  = '{default: 1'b0}; stim_a = '{default: 1'b0}; stim_ab = '{default: 1'b0};
        stim_v[0] = 1; stim_a[0] = 1;
        stim_v[2] = 1; stim_a[2] = 0;
        stim_v[4] = 1; stim_a[4] = 1;
        stim_v[6] = 1; stim_a[6] = 1; stim_ab[6] = 1;
        run_case(8'h0B, 4'd4, 8'd0, 16'd0, "abort");
        check("abort status", 32'(got_st), 32'(ST_ABORT));
        check("abort cnt", 32'(got_cnt), 32'(0));
        check("abort matches", 32'(dut_matches), 32'(0));
        check("abort done at", 32'(dut_done_at), 32'(7));

        // Asynchronous reset in the middle of SCAN.
        cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_limit = 8'd0; cfg_window = 16'd0;
        cfg_valid = 1'b1; a_valid = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(posedge clk); #1;
        a_valid = 1'b1; a = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("mid cnt", 32'(match_cnt), 32'(2));
        check("mid busy", 32'(busy), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("arst cfg_ready", 32'(cfg_ready), 32'(1));
        check("arst busy", 32'(busy), 32'(0));
        check("arst match", 32'(match), 32'(0));
        check("arst done", 32'(done), 32'(0));
        check("arst status", 32'(status), 32'(ST_NONE));
        check("arst cnt", 32'(match_cnt), 32'(0));
        a_valid = 1'b0; a = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("after arst ready", 32'(cfg_ready), 32'(1));
        check("after arst busy", 32'(busy), 32'(0));

        for (int r = 0; r < 40; r++) begin
            logic [7:0]  pat;
            logic [3:0]  len;
            logic [7:0]  lim;
            logic [15:0] win;
            pat = 8'($urandom);
            if ($urandom_range(0, 1) == 1) len = 4'($urandom_range(1, 3));
            else len = 4'($urandom_range(0, 10));
            lim = 8'($urandom_range(0, 3));
            win = ($urandom_range(0, 2) != 0) ? 16'($urandom_range(1, 25)) : 16'd0;
            stim_n = $urandom_range(1, 40);
            for (int i = 0; i < stim_n; i++) begin
                stim_v[i]  = ($urandom_range(0, 3) != 0);
                stim_a[i]  = 1'($urandom_range(0, 1));
                stim_ab[i] = ($urandom_range(0, 40) == 0);
            end
            run_case(pat, len, lim, win, $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
